seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 4: operand and result width in bits, N >= 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1: request a division; sampled only in IDLE or DONE.
REQ-005 SHALL have port dividend, input, N: unsigned dividend, captured with start.
REQ-006 SHALL have port divisor, input, N: unsigned divisor, captured with start.
REQ-007 SHALL have port busy, output, 1: high while in CALC.
REQ-008 SHALL have port done, output, 1: one-cycle pulse; results valid.
REQ-009 SHALL have port quotient, output, N: unsigned quotient, registered.
REQ-010 SHALL have port remainder, output, N: unsigned remainder, registered.
REQ-011 SHALL have port div_by_zero, output, 1: registered flag, set when the captured divisor was 0.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 IDLE or DONE with start=1 and divisor!=0 SHALL capture the operands, clear the partial remainder, load count=N-1 and go to CALC.
REQ-014 IDLE or DONE with start=1 and divisor==0 SHALL go directly to DONE with quotient=all ones, remainder=dividend and div_by_zero=1.
REQ-015 Each CALC cycle SHALL perform one restoring step, MSB first:
- trial = {rem[N-1:0], next dividend bit} minus divisor, computed at N+1 bits;
- if the trial is non-negative: rem=trial and quotient bit=1;
- otherwise: rem is shifted only and quotient bit=0.
REQ-016 CALC SHALL last exactly N cycles; at count==0 the FSM SHALL go to DONE.
REQ-017 Latency: start in cycle 0 -> CALC in cycles 1..N -> done=1 in cycle N+1 (cycle 1 for divide-by-zero).
REQ-018 DONE with start=0 SHALL return to IDLE.
REQ-019 quotient, remainder and div_by_zero SHALL update only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-020 div_by_zero SHALL clear on any start accepted with divisor!=0.
REQ-021 start during CALC SHALL be ignored; the operation in progress and its results SHALL be unaffected.
REQ-022 Operand inputs SHALL be ignored except in the cycle where start is accepted.
REQ-023 Results SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for all divisor != 0.
REQ-024 busy SHALL equal (state==CALC); done SHALL equal (state==DONE).

Reset
REQ-025 rst_n=0 at a clock edge SHALL force state=IDLE, with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and count=0.
REQ-026 Reset mid-CALC SHALL abort the division with no done pulse, and the outputs SHALL read 0.
REQ-027 Reset SHALL take priority over start.

Structure
REQ-028 The state enum and the default width constant SHALL live in the shared package calc_pkg.
REQ-029 The combinational trial subtract of REQ-015 SHALL be one sub-module, restore_step (parameter N; outputs difference and non-negative flag).
REQ-030 The FSM, shift registers and counter SHALL remain in seq_divider.

Verification (N=4)
REQ-031 13/4, start in cycle 0 -> done in cycle 5, quotient=3, remainder=1, div_by_zero=0, busy high in cycles 1-4.
REQ-032 15/1 -> quotient=15, remainder=0; 3/9 -> quotient=0, remainder=3.
REQ-033 7/0 -> done in cycle 1, quotient=15, remainder=7, div_by_zero=1; the next 8/2 -> quotient=4, remainder=0, div_by_zero=0.
REQ-034 Start 13/4, then start=1 with 9/3 in cycle 2 -> ignored; done in cycle 5 with quotient=3, remainder=1.
REQ-035 Start 13/4, then rst_n=0 in cycle 3 -> IDLE next cycle, no done, all outputs 0; a new 12/5 afterwards -> quotient=2, remainder=2.
REQ-036 Back-to-back: start held high through DONE -> 6/3 then 14/4 -> results quotient=2/remainder=0 and quotient=3/remainder=2, second done 5 cycles after the first.
REQ-037 Random all-operand sweep checking REQ-023 against a reference model.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential divider.
package calc_pkg;

  localparam int DIV_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/restore_step.sv
// One restoring-division trial subtract: {rem, next bit} - divisor.
module restore_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] diff,
  output logic         non_neg
);

  logic [N+1:0] trial;

  always_comb begin
    trial   = {1'b0, rem_in, bit_in} - {2'b00, divisor};
    // With rem_in < divisor, a non-negative trial is always below divisor, so bit N is zero.
    non_neg = ~|trial[N+1:N];
    diff    = trial[N-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
module seq_divider
  import calc_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   dq_q, dq_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;

  logic [N-1:0]   step_diff;
  logic           step_non_neg;
  logic [N-1:0]   next_rem;
  logic [N-1:0]   next_dq;

  // dq_q shifts dividend bits out of the MSB while quotient bits enter at the LSB.
  restore_step #(.N(N)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dq_q[N-1]),
    .divisor (dvsr_q),
    .diff    (step_diff),
    .non_neg (step_non_neg)
  );

  always_comb begin
    next_rem = step_non_neg ? step_diff : {rem_q[N-2:0], dq_q[N-1]};
    next_dq  = {dq_q[N-2:0], step_non_neg};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dq_d        = dq_q;
    dvsr_d      = dvsr_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != '0) begin
            dq_d    = dividend;
            dvsr_d  = divisor;
            rem_d   = '0;
            count_d = CW'(N - 1);
            dbz_d   = 1'b0;
            state_d = CALC;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = next_rem;
        dq_d  = next_dq;
        if (count_q == '0) begin
          quotient_d  = next_dq;
          remainder_d = next_rem;
          state_d     = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dq_q        <= '0;
      dvsr_q      <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dq_q        <= dq_d;
      dvsr_q      <= dvsr_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (N=4): vector table, corner sequences and exhaustive sweep.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (done) begin
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r, input logic dbz);
    int c0;
    int lat;
    sb.push_back('{q: q, r: r, dbz: dbz});
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    c0       = cyc;
    tick();
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    lat      = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      if (done) lat = cyc - c0;
      else tick();
    end
    chk("latency", 32'(lat), (b == '0) ? 32'd1 : 32'(N + 1));
    tick();
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1,  dbz: 1'b0};
    vecs[1]  = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0,  dbz: 1'b0};
    vecs[2]  = '{a: 4'd3,  b: 4'd9,  q: 4'd0,  r: 4'd3,  dbz: 1'b0};
    vecs[3]  = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7,  dbz: 1'b1};
    vecs[4]  = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0,  dbz: 1'b0};
    vecs[5]  = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0,  dbz: 1'b0};
    vecs[6]  = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0,  dbz: 1'b0};
    vecs[7]  = '{a: 4'd14, b: 4'd3,  q: 4'd4,  r: 4'd2,  dbz: 1'b0};
    vecs[8]  = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0,  dbz: 1'b1};
    vecs[9]  = '{a: 4'd1,  b: 4'd15, q: 4'd0,  r: 4'd1,  dbz: 1'b0};
    vecs[10] = '{a: 4'd15, b: 4'd0,  q: 4'd15, r: 4'd15, dbz: 1'b1};
    vecs[11] = '{a: 4'd12, b: 4'd5,  q: 4'd2,  r: 4'd2,  dbz: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // 13/4 with busy window cycles 1..4 and done in cycle 5
    sb.push_back('{q: 4'd3, r: 4'd1, dbz: 1'b0});
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    tick();
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("busy_c%0d", k), 32'(busy), (k <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("done_c%0d", k), 32'(done), (k == 5) ? 32'd1 : 32'd0);
      tick();
    end
    chk("done_to_idle", 32'(done), 32'd0);

    for (int i = 0; i < 12; i++)
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // start during CALC is ignored
    begin
      int c0;
      sb.push_back('{q: 4'd3, r: 4'd1, dbz: 1'b0});
      start = 1'b1; dividend = 4'd13; divisor = 4'd4;
      c0 = cyc;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; dividend = 4'd9; divisor = 4'd3;
      tick();
      start = 1'b0;
      for (int k = 0; k < 20 && !done; k++) tick();
      chk("ignored_start_latency", 32'(cyc - c0), 32'(N + 1));
      tick();
    end

    // reset in cycle 3 of a division
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    for (int k = 0; k < 6; k++) tick();
    run_div(4'd12, 4'd5, 4'd2, 4'd2, 1'b0);

    // back-to-back with start held through DONE
    begin
      int d1;
      int d2;
      sb.push_back('{q: 4'd2, r: 4'd0, dbz: 1'b0});
      sb.push_back('{q: 4'd3, r: 4'd2, dbz: 1'b0});
      start = 1'b1; dividend = 4'd6; divisor = 4'd3;
      tick();
      dividend = 4'd14; divisor = 4'd4;
      d1 = -1;
      for (int k = 0; k < 20 && d1 < 0; k++) begin
        if (done) d1 = cyc;
        else tick();
      end
      tick();
      start = 1'b0;
      d2 = -1;
      for (int k = 0; k < 20 && d2 < 0; k++) begin
        if (done) d2 = cyc;
        else tick();
      end
      chk("b2b_spacing", 32'(d2 - d1), 32'(N + 1));
      tick();
    end

    // exhaustive operand sweep against arithmetic reference
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) run_div(N'(a), N'(b), '1, N'(a), 1'b1);
        else        run_div(N'(a), N'(b), N'(a / b), N'(a % b), 1'b0);
      end
    end

    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
